seg_display_ctrl: RTL and testbench
===================================

Name: seg_display_ctrl

Overview:
Parametrised multi-digit hex display controller for the board's active-low 7-segment banks.
- Captures a data word through a valid/ready handshake.
- Pages through words wider than the display using a debounced pushbutton.
- Refreshes the registered segment outputs one digit per cycle with a small FSM.
- Sits between the register-bank readout and the HEXn pins; replaces per-nibble converter instances.

Parameters:
NUM_DIGITS, 8, number of 7-segment digits driven (>=1)
DATA_W, 32, width of displayed word; multiple of 4
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a key level change (>=2)
Derived: PAGES = ceil(DATA_W / (4*NUM_DIGITS)); PAGE_W = max(1, clog2(PAGES))

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
data_in  in  DATA_W  word to display
load_valid  in  1  data_in valid
load_ready  out  1  controller can accept a load
key_n  in  1  raw pushbutton, active-low, asynchronous to clk
seg  out  7*NUM_DIGITS  active-low segments; digit i at seg[7i+6:7i]; bit0=a ... bit6=g
page  out  PAGE_W  currently displayed page
busy  out  1  update pass in progress
update_done  out  1  one-cycle pulse when a pass completes

Behaviour:
- Reset values: seg all 1 (blank, 7'h7F per digit); load_ready=1; busy=0; update_done=0; page=0; shadow word=0; pending=0; debounced key=released.
- FSM states:
  - IDLE: load_ready=1, busy=0.
  - UPDATE: load_ready=0, busy=1, digit index counts NUM_DIGITS-1 down to 0.
- Load: load_valid&&load_ready at edge N → shadow<=data_in; state UPDATE with index=NUM_DIGITS-1.
  - At edge N+k (k=1..NUM_DIGITS), digit NUM_DIGITS-k is written.
  - At edge N+NUM_DIGITS: state returns to IDLE; update_done=1 for exactly that following cycle; load_ready high again.
  - Total latency: NUM_DIGITS cycles. load_valid while load_ready=0 is ignored; the data is not queued.
- Digit content: digit i on page p shows nibble shadow[4*(p*NUM_DIGITS+i) +: 4]. A nibble position >= DATA_W is blanked (7F).
- Encoding, active-low hex 0-F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
- Key path:
  - key_n passes through a 2-flop synchroniser.
  - A counter resets on any mismatch between the synchronised level and the debounced level. When it reaches DEBOUNCE_CYCLES, the debounced level takes the new value.
  - A press event is a debounced transition to pressed (0). Release generates nothing.
- On a press event: page <= (page+1) mod PAGES in the same cycle (page stays 0 if PAGES==1), and pending<=1.
- In IDLE with pending=1: start an update pass with the unchanged shadow and clear pending. A press during UPDATE sets pending, which is serviced after the current pass, so the display shows the final page.
- Simultaneous load accept and pending in IDLE: one pass with the new data and the new page; pending cleared.
- Reset mid-pass: all state returns to reset values immediately; the partial display is blanked.
- seg digits not yet rewritten keep their old values during a pass.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: during a pass, a digit whose nibble is 0 is blanked if every more-significant nibble of the whole shadow word is also 0. This includes higher pages, which are checked combinationally at pass start to seed a seen_nonzero flag. The MSD-first walk then sets seen_nonzero on the first nonzero nibble. Digit 0 of page 0 is never blanked.
- Undefined: zeros display as 40.

Test Plan:
- NUM_DIGITS=4, DATA_W=32, rst 2 cycles → seg=28'hFFFFFFF, load_ready=1, page=0, busy=0.
- Load 32'h1234ABCD → load_ready low for 4 cycles; then digits 3..0 = 08,03,46,21; update_done pulses once; page=0.
- key_n held low ≥DEBOUNCE_CYCLES+2 → page=1; after 4 cycles digits = 79,24,30,19. A second press → page=0; digits again show ABCD.
- key_n low glitch of DEBOUNCE_CYCLES-2 cycles → no page change, no pass. Load 32'h55555555 with load_valid during busy → ignored; display unchanged.
- Assert rst at the 2nd cycle of a pass → next cycle seg all 7F, busy=0, pending=0, page=0.
- Load 32'h000000A5: with LEADING_ZERO_BLANK_EN → page0 = 7F,7F,08,12 and page1 all 7F. Without the macro → 40,40,08,12 and page1 = 40,40,40,40.

Source files
------------

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl -- multi-digit active-low hex 7-segment display controller.
//
// Captures a word through a valid/ready handshake. A debounced pushbutton pages
// through words wider than the display. A two-state FSM rewrites one digit per
// cycle, most-significant digit first.
//
// Optional build macro: LEADING_ZERO_BLANK_EN. When it is defined, leading zeros
// of the whole shadow word are blanked. Digit 0 of page 0 is never blanked.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   data_in       word to display; taken when load_valid && load_ready
//   load_valid    data_in valid
//   load_ready    high in IDLE; the controller can accept a load
//   key_n         raw active-low pushbutton, asynchronous to clk
//   seg           active-low segments, digit i at seg[7i+6:7i], bit0=a..bit6=g
//   page          page currently selected for display
//   busy          update pass in progress
//   update_done   one-cycle pulse after a pass completes

module seg_display_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [6:0] code,
  output logic [6:0] seg
);
  always_ff @(posedge clk) begin
    if (rst)     seg <= 7'h7F;
    else if (wr) seg <= code;
  end
endmodule

module seg_display_ctrl #(
  parameter  int NUM_DIGITS      = 8,
  parameter  int DATA_W          = 32,
  parameter  int DEBOUNCE_CYCLES = 16,
  localparam int PAGES  = (DATA_W + 4*NUM_DIGITS - 1) / (4*NUM_DIGITS),
  localparam int PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic                    key_n,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic [PAGE_W-1:0]       page,
  output logic                    busy,
  output logic                    update_done
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int NT    = PAGES * NUM_DIGITS;   // nibble slots over all pages
  localparam int POS_W = (NT > 1) ? $clog2(NT) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic {IDLE, UPDATE} state_t;
  state_t state, state_nxt;

  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shadow;
  logic [PAGE_W-1:0] page_nxt, pass_page;
  logic              pending, load_fire, start, fin;
  logic              sync1, sync2, key_db, db_flip, press;
  logic [CNT_W-1:0]  db_cnt;
  logic [POS_W-1:0]  pos;
  logic [4:0]        nibv [NT];   // {in-range, nibble}
  logic [4:0]        cur;
  logic              blank;
  logic [6:0]        code;
  logic [NUM_DIGITS-1:0][6:0] seg_q;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40; 4'h1: hex7 = 7'h79; 4'h2: hex7 = 7'h24; 4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19; 4'h5: hex7 = 7'h12; 4'h6: hex7 = 7'h02; 4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00; 4'h9: hex7 = 7'h10; 4'hA: hex7 = 7'h08; 4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46; 4'hD: hex7 = 7'h21; 4'hE: hex7 = 7'h06; default: hex7 = 7'h0E;
    endcase
  endfunction

  assign load_ready = (state == IDLE);
  assign busy       = (state == UPDATE);
  assign load_fire  = load_valid && load_ready;

  // Debounced level flips on the DEBOUNCE_CYCLES-th consecutive mismatch.
  assign db_flip  = (sync2 != key_db) && (db_cnt == CNT_W'(DEBOUNCE_CYCLES-1));
  assign press    = db_flip && !sync2;
  assign page_nxt = !press ? page :
                    (page == PAGE_W'(PAGES-1)) ? '0 : page + 1'b1;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE:   if (load_fire || pending) begin start = 1'b1; state_nxt = UPDATE; end
      UPDATE: if (idx == '0) begin fin = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1; sync2 <= 1'b1; key_db <= 1'b1; db_cnt <= '0;
      page <= '0; pending <= 1'b0; update_done <= 1'b0;
      shadow <= '0; idx <= '0; pass_page <= '0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      if (sync2 == key_db) db_cnt <= '0;
      else if (db_flip) begin key_db <= sync2; db_cnt <= '0; end
      else db_cnt <= db_cnt + 1'b1;
      page <= page_nxt;
      if (press)      pending <= 1'b1;   // a press during a start still earns a pass
      else if (start) pending <= 1'b0;
      update_done <= fin;
      if (load_fire) shadow <= data_in;
      if (start) begin
        idx       <= IDX_W'(NUM_DIGITS-1);
        pass_page <= page_nxt;           // page frozen for the whole pass
      end else if (busy && idx != '0) begin
        idx <= idx - 1'b1;
      end
    end
  end

  // Nibble table over all pages; slots past DATA_W are out of range (blank).
  for (genvar j = 0; j < NT; j++) begin : g_nib
    if (j < DATA_W/4) begin : g_in
      assign nibv[j] = {1'b1, shadow[4*j +: 4]};
    end else begin : g_out
      assign nibv[j] = 5'b0;
    end
  end

  assign pos = POS_W'(pass_page) * POS_W'(NUM_DIGITS) + POS_W'(idx);
  assign cur = nibv[pos];

`ifdef LEADING_ZERO_BLANK_EN
  logic              seen_nz, seed_nz;
  logic [DATA_W-1:0] word_nxt;
  assign word_nxt = load_fire ? data_in : shadow;

  // Any nonzero nibble on pages above the one about to be shown.
  always_comb begin
    seed_nz = 1'b0;
    for (int j = 0; j < DATA_W/4; j++)
      if (j >= (int'(page_nxt) + 1) * NUM_DIGITS && word_nxt[4*j +: 4] != 4'h0)
        seed_nz = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)        seen_nz <= 1'b0;
    else if (start) seen_nz <= seed_nz;
    else if (busy && cur[4] && cur[3:0] != 4'h0) seen_nz <= 1'b1;
  end

  assign blank = !seen_nz && cur[3:0] == 4'h0 && !(pass_page == '0 && idx == '0);
`else
  assign blank = 1'b0;
`endif

  assign code = (!cur[4] || blank) ? 7'h7F : hex7(cur[3:0]);

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    seg_display_digit u_dig (
      .clk  (clk),
      .rst  (rst),
      .wr   (busy && idx == IDX_W'(i)),
      .code (code),
      .seg  (seg_q[i])
    );
  end

  assign seg = seg_q;
endmodule

// File: tb/tb_seg_display_ctrl.sv
module tb_seg_display_ctrl;
  localparam int ND = 4, DW = 32, DB = 16;

  logic        clk = 1'b0;
  logic        rst, load_valid, key_n;
  logic [31:0] data_in;
  logic        load_ready, busy, update_done;
  logic [27:0] seg;
  logic [0:0]  page;
  int checks = 0, errors = 0;

  seg_display_ctrl #(.NUM_DIGITS(ND), .DATA_W(DW), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready), .key_n(key_n), .seg(seg), .page(page),
    .busy(busy), .update_done(update_done)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] s4(input logic [6:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Hold the key low until the page moves; returns edges taken or -1.
  task automatic press_key(output int n);
    logic [0:0] p0;
    p0 = page; n = -1; key_n = 1'b0;
    for (int i = 1; i <= DB + 10 && n < 0; i++) begin
      tick;
      if (page != p0) n = i;
    end
    key_n = 1'b1;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick;
      if (update_done) ok = 1'b1;
    end
  endtask

  task automatic idle_wait(input int n, output bit saw_busy);
    saw_busy = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick;
      if (busy) saw_busy = 1'b1;
    end
  endtask

  logic [27:0] abcd, p1, lz0, lz1;
  int  n;
  bit  ok, sb;

  initial begin
    abcd = s4(7'h08, 7'h03, 7'h46, 7'h21);
    p1   = s4(7'h79, 7'h24, 7'h30, 7'h19);
`ifdef LEADING_ZERO_BLANK_EN
    lz0 = s4(7'h7F, 7'h7F, 7'h08, 7'h12);
    lz1 = s4(7'h7F, 7'h7F, 7'h7F, 7'h7F);
`else
    lz0 = s4(7'h40, 7'h40, 7'h08, 7'h12);
    lz1 = s4(7'h40, 7'h40, 7'h40, 7'h40);
`endif
    rst = 1'b1; load_valid = 1'b0; key_n = 1'b1; data_in = '0;
    tick; tick;
    rst = 1'b0;
    chk("rst_seg", seg, 28'hFFFFFFF);
    chk("rst_ready", load_ready, 1);
    chk("rst_page", page, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", update_done, 0);
    tick;

    // Load and digit-by-digit pass
    data_in = 32'h1234ABCD; load_valid = 1'b1;
    tick;
    load_valid = 1'b0;
    chk("ld_ready_low", load_ready, 0);
    chk("ld_busy", busy, 1);
    tick;
    chk("ld_first_digit", seg, s4(7'h08, 7'h7F, 7'h7F, 7'h7F));
    tick; tick;
    chk("ld_ready_low4", load_ready, 0);
    chk("ld_done_pulse", update_done, 0);
    tick;
    chk("ld_ready_back", load_ready, 1);
    chk("ld_done_pulse", update_done, 1);
    chk("ld_seg", seg, abcd);
    chk("ld_page", page, 0);
    tick;
    chk("ld_done_once", update_done, 0);

    // Key press -> page 1
    press_key(n);
    chk("press1_lat", n, DB + 2);
    chk("press1_page", page, 1);
    wait_done(ok);
    chk("press1_pass", ok, 1);
    chk("press1_seg", seg, p1);
    idle_wait(DB + 4, sb);
    chk("release_nopass", sb, 0);
    chk("release_page", page, 1);

    // Second press wraps to page 0
    press_key(n);
    chk("press2_page", page, 0);
    wait_done(ok);
    chk("press2_pass", ok, 1);
    chk("press2_seg", seg, abcd);
    idle_wait(DB + 4, sb);

    // Short glitch is filtered
    key_n = 1'b0;
    for (int i = 0; i < DB - 2; i++) tick;
    key_n = 1'b1;
    idle_wait(DB + 4, sb);
    chk("glitch_nopass", sb, 0);
    chk("glitch_page", page, 0);
    chk("glitch_seg", seg, abcd);

    // Load attempt while busy is dropped
    data_in = 32'h1234ABCD; load_valid = 1'b1;
    tick;
    data_in = 32'h55555555;
    tick; tick; tick;
    load_valid = 1'b0;
    tick;
    chk("busyld_done", update_done, 1);
    idle_wait(6, sb);
    chk("busyld_nopass", sb, 0);
    chk("busyld_seg", seg, abcd);

    // Reset in the second cycle of a pass
    press_key(n);
    chk("rstmid_page1", page, 1);
    tick;
    chk("rstmid_busy", busy, 1);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rstmid_seg", seg, 28'hFFFFFFF);
    chk("rstmid_busy0", busy, 0);
    chk("rstmid_page0", page, 0);
    chk("rstmid_ready", load_ready, 1);
    idle_wait(6, sb);
    chk("rstmid_nopend", sb, 0);

    // Leading zeros
    data_in = 32'h000000A5; load_valid = 1'b1;
    tick;
    load_valid = 1'b0;
    wait_done(ok);
    chk("lz_pass0", ok, 1);
    chk("lz_page0", seg, lz0);
    idle_wait(2, sb);
    press_key(n);
    wait_done(ok);
    chk("lz_pass1", ok, 1);
    chk("lz_pg", page, 1);
    chk("lz_page1", seg, lz1);

    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
